// File: rtl/burst_serializer.sv
// Write-line to beat serializer and read-burst tracker for the bmem interface.
// Optional: define BURST_SERIALIZER_BEAT_ADDR_INC_EN to step bmem_addr per write beat.
module burst_serializer #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic                  dfp_resp,
    input  logic                  bmem_ready,
    input  logic                  bmem_rvalid,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    output logic                  busy
);

    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W      = $clog2(BEATS);
    localparam int LINE_OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int BEAT_OFF_W = $clog2(BEAT_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << LINE_OFF_W;
    localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_BEAT = 3'd1,
        WR_DONE = 3'd2,
        RD_CMD  = 3'd3,
        RD_WAIT = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [LINE_WIDTH-1:0]   line_r, line_s;

    logic                    dfp_resp_s;
    logic [ADDR_WIDTH-1:0]   bmem_addr_s;
    logic                    bmem_read_s;
    logic                    bmem_write_s;
    logic [BEAT_WIDTH-1:0]   bmem_wdata_s;
    logic                    busy_s;

    // State, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            addr_r     <= {ADDR_WIDTH{1'b0}};
            line_r     <= {LINE_WIDTH{1'b0}};
            dfp_resp   <= 1'b0;
            bmem_addr  <= {ADDR_WIDTH{1'b0}};
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= {BEAT_WIDTH{1'b0}};
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            addr_r     <= addr_s;
            line_r     <= line_s;
            dfp_resp   <= dfp_resp_s;
            bmem_addr  <= bmem_addr_s;
            bmem_read  <= bmem_read_s;
            bmem_write <= bmem_write_s;
            bmem_wdata <= bmem_wdata_s;
            busy       <= busy_s;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register cleanly
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        addr_s       = addr_r;
        line_s       = line_r;
        dfp_resp_s   = 1'b0;
        bmem_addr_s  = {ADDR_WIDTH{1'b0}};
        bmem_read_s  = 1'b0;
        bmem_write_s = 1'b0;
        bmem_wdata_s = {BEAT_WIDTH{1'b0}};
        busy_s       = 1'b0;

        case (state_r)
            IDLE: begin
                if (dfp_write && bmem_ready) begin
                    addr_s  = dfp_addr & ALIGN_MASK;
                    line_s  = dfp_wdata;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = WR_BEAT;
                end else if (dfp_read && bmem_ready) begin
                    addr_s  = dfp_addr & ALIGN_MASK;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = RD_CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_BEAT: begin
                // bmem_ready is deliberately not consulted: a started burst never stalls
                if (cnt_r == LAST_BEAT) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = WR_DONE;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            WR_DONE: begin
                state_s = IDLE;
            end
            RD_CMD: begin
                cnt_s   = {CNT_W{1'b0}};
                state_s = RD_WAIT;
            end
            RD_WAIT: begin
                if (bmem_rvalid) begin
                    if (cnt_r == LAST_BEAT) begin
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = IDLE;
                    end else begin
                        cnt_s   = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                cnt_s   = {CNT_W{1'b0}};
                state_s = IDLE;
            end
        endcase

        case (state_s)
            WR_BEAT: begin
                bmem_write_s = 1'b1;
                bmem_wdata_s = line_s[BEAT_WIDTH*int'(cnt_s) +: BEAT_WIDTH];
`ifdef BURST_SERIALIZER_BEAT_ADDR_INC_EN
                bmem_addr_s  = addr_s + (ADDR_WIDTH'(cnt_s) << BEAT_OFF_W);
`else
                bmem_addr_s  = addr_s;
`endif
            end
            WR_DONE: begin
                dfp_resp_s = 1'b1;
            end
            RD_CMD: begin
                bmem_read_s = 1'b1;
                bmem_addr_s = addr_s;
            end
            default: begin
                bmem_read_s = 1'b0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

endmodule

// File: tb/tb_burst_serializer.sv
// Scoreboard bench for burst_serializer: expected beats/commands queued at drive time,
// popped and compared by a negedge monitor.
module tb_burst_serializer;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int BW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] dfp_addr;
    logic          dfp_read;
    logic          dfp_write;
    logic [LW-1:0] dfp_wdata;
    logic          dfp_resp;
    logic          bmem_ready;
    logic          bmem_rvalid;
    logic [AW-1:0] bmem_addr;
    logic          bmem_read;
    logic          bmem_write;
    logic [BW-1:0] bmem_wdata;
    logic          busy;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] exp_data_q[$];
    logic [AW-1:0] exp_waddr_q[$];
    logic [AW-1:0] exp_raddr_q[$];

    burst_serializer #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_resp   (dfp_resp),
        .bmem_ready (bmem_ready),
        .bmem_rvalid(bmem_rvalid),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: every write beat and read command must match the head of its queue
    always @(negedge clk) begin
        if (bmem_write) begin
            if (exp_data_q.size() == 0) begin
                check_eq("unexpected_wbeat", 64'd1, 64'd0);
            end else begin
                check_eq("wbeat_data", bmem_wdata, exp_data_q.pop_front());
                check_eq("wbeat_addr", 64'(bmem_addr), 64'(exp_waddr_q.pop_front()));
            end
        end
        if (bmem_read) begin
            if (exp_raddr_q.size() == 0) begin
                check_eq("unexpected_rcmd", 64'd1, 64'd0);
            end else begin
                check_eq("rcmd_addr", 64'(bmem_addr), 64'(exp_raddr_q.pop_front()));
            end
        end
    end

    task automatic push_line(input logic [AW-1:0] addr, input logic [LW-1:0] data);
        logic [AW-1:0] base;
        base = addr & 32'hFFFF_FFE0;
        for (int k = 0; k < 4; k++) begin
            exp_data_q.push_back(data[k*BW +: BW]);
`ifdef BURST_SERIALIZER_BEAT_ADDR_INC_EN
            exp_waddr_q.push_back(base + 32'(k * 8));
`else
            exp_waddr_q.push_back(base);
`endif
        end
    endtask

    // Full write; optionally drops bmem_ready mid-burst and/or holds dfp_read too
    task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] data,
                            input bit drop_ready, input bit with_read);
        @(negedge clk);
        dfp_addr   = addr;
        dfp_wdata  = data;
        dfp_write  = 1'b1;
        dfp_read   = with_read;
        bmem_ready = 1'b1;
        push_line(addr, data);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) begin
                dfp_wdata = ~data;
                dfp_addr  = addr + 32'h0000_0100;
            end
            if (n == 2 && drop_ready) bmem_ready = 1'b0;
            check_eq("wr_resp", 64'(dfp_resp), 64'(n == 5));
            check_eq("wr_busy", 64'(busy), 64'(n <= 5));
            if (n == 5) begin
                dfp_write  = 1'b0;
                dfp_read   = 1'b0;
                bmem_ready = 1'b1;
            end
        end
        check_eq("wr_drained", 64'(exp_data_q.size()), 64'd0);
    endtask

    initial begin
        logic [LW-1:0] line_a;
        bit [1:0] rv_pat [8];
        rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0;
        dfp_wdata = '0; bmem_ready = 1'b0; bmem_rvalid = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_write", 64'(bmem_write), 64'd0);
        check_eq("rst_read", 64'(bmem_read), 64'd0);
        check_eq("rst_resp", 64'(dfp_resp), 64'd0);
        check_eq("rst_addr", 64'(bmem_addr), 64'd0);
        check_eq("rst_wdata", bmem_wdata, 64'd0);

        rst = 1'b0;
        dfp_write = 1'b1; dfp_addr = 32'h0000_2004;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("noready_write", 64'(bmem_write), 64'd0);
            check_eq("noready_busy", 64'(busy), 64'd0);
        end
        dfp_write = 1'b0;

        line_a = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                  64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
        do_write(32'h0000_2004, line_a, 1'b0, 1'b0);

        do_write(32'h0003_FF7F, {$urandom, $urandom, $urandom, $urandom,
                                 $urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);

        // Read: a stray rvalid during the command cycle must not count
        @(negedge clk);
        dfp_read = 1'b1; dfp_addr = 32'h0000_1000; bmem_ready = 1'b1;
        exp_raddr_q.push_back(32'h0000_1000);
        rv_pat = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            check_eq("rd_resp", 64'(dfp_resp), 64'd0);
            check_eq("rd_busy", 64'(busy), 64'(n <= 8));
            check_eq("rd_cmd", 64'(bmem_read), 64'(n == 1));
            if (n <= 8) bmem_rvalid = rv_pat[n-1][0];
            else begin
                bmem_rvalid = 1'b0;
                dfp_read    = 1'b0;
            end
        end
        check_eq("rd_cmd_seen", 64'(exp_raddr_q.size()), 64'd0);

        do_write(32'h0000_4040, ~line_a, 1'b0, 1'b1);

        // Reset after the second beat of a write aborts the burst silently
        @(negedge clk);
        dfp_addr = 32'h0000_5000; dfp_wdata = line_a; dfp_write = 1'b1;
        push_line(32'h0000_5000, line_a);
        repeat (2) @(negedge clk);
        rst = 1'b1; dfp_write = 1'b0;
        @(negedge clk);
        check_eq("abort_write", 64'(bmem_write), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_beats", 64'(exp_data_q.size()), 64'd2);
        exp_data_q.delete();
        exp_waddr_q.delete();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("abort_resp", 64'(dfp_resp), 64'd0);
        end

        do_write(32'h0000_6020, {line_a[127:0], line_a[255:128]}, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/burst_serializer.md
Name: burst_serializer

Overview:
- Transmit-side counterpart of the read deserializer.
- Accepts one cache-line request from the DFP (cache miss/writeback) side and drives the burst-memory (bmem) interface.
- Writes: latches a 256-bit line and emits it as 4 consecutive 64-bit write beats.
- Reads: issues the single-cycle read command, then tracks the 4 returning rvalid beats so no new request overlaps an in-flight burst.

Parameters:
- LINE_WIDTH, 256, bits per cache line on DFP side.
- BEAT_WIDTH, 64, bits per bmem beat; BEATS = LINE_WIDTH/BEAT_WIDTH (4), must be a power of two ≥2.
- ADDR_WIDTH, 32, address width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- dfp_addr  input  ADDR_WIDTH  line address; low log2(LINE_WIDTH/8) bits ignored (forced 0).
- dfp_read  input  1  line read request, held until done.
- dfp_write  input  1  line write request, held until dfp_resp.
- dfp_wdata  input  LINE_WIDTH  write line; beat k = bits [64k+63:64k].
- dfp_resp  output  1  one-cycle write-complete pulse.
- bmem_ready  input  1  memory can accept a new command.
- bmem_rvalid  input  1  read beat valid (counted only).
- bmem_addr  output  ADDR_WIDTH  command/beat address.
- bmem_read  output  1  read command, one cycle.
- bmem_write  output  1  write beat valid.
- bmem_wdata  output  BEAT_WIDTH  write beat data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values: all outputs 0; state=IDLE; beat counter=0; latched addr/data=0. Reset mid-burst aborts immediately, with no further beats and no dfp_resp.
- States: IDLE, WR_BEAT, WR_DONE, RD_CMD, RD_WAIT.
- IDLE, write accept:
  - Condition: dfp_write && bmem_ready. Write has priority if dfp_read is also high.
  - Latch aligned addr and dfp_wdata; cnt=0; go to WR_BEAT.
- IDLE, read accept:
  - Condition: dfp_read && !dfp_write && bmem_ready. Latch aligned addr; go to RD_CMD.
- IDLE, no accept: with bmem_ready=0, stay in IDLE; requests wait.
- WR_BEAT:
  - bmem_write=1, bmem_wdata=latched[cnt], bmem_addr=latched aligned addr.
  - cnt increments each cycle; bmem_ready is ignored once a burst has started (no mid-burst stall).
  - After cnt==BEATS-1, go to WR_DONE.
- WR_DONE: dfp_resp=1 for exactly one cycle; go to IDLE.
- Write timing: accept at cycle N gives beats at N+1..N+4 and dfp_resp at N+5. The requester drops dfp_write after sampling resp, so there is no re-accept at N+6.
- dfp_wdata/dfp_addr changes after acceptance have no effect.
- RD_CMD: bmem_read=1, bmem_addr=aligned addr for one cycle; go to RD_WAIT with rcnt=0.
- RD_WAIT:
  - Count bmem_rvalid beats; gaps are allowed.
  - On the BEATS-th beat, go to IDLE. The next request is accepted no earlier than the cycle after the last beat.
  - dfp_resp is never driven for reads; the deserializer owns the read response.
- bmem_rvalid outside RD_WAIT is ignored.
- Counters are log2(BEATS) bits; rcnt wraps to 0 on the transition back to IDLE.

Optional Feature:
- Macro: BURST_SERIALIZER_BEAT_ADDR_INC_EN.
- When defined: during WR_BEAT, bmem_addr = aligned addr + cnt*(BEAT_WIDTH/8), i.e. +0x0, +0x8, +0x10, +0x18.
- When undefined (default): bmem_addr holds the aligned line address for all beats. RD_CMD behaviour is unchanged in both cases.

Test Plan:
- Reset: rst=1 for 2 cycles → all outputs 0, busy=0. Then dfp_write=1 with bmem_ready=0 for 3 cycles → bmem_write stays 0.
- Write: addr=0x2004, wdata=0x8888..._7777..._6666..._5555... (64-bit fields), bmem_ready=1.
  - Expected: bmem_write=1 for 4 cycles with wdata 0x5555_5555_5555_5555, 0x6666…, 0x7777…, 0x8888…, in that order.
  - bmem_addr=0x2000 on every beat (0x2000/08/10/18 with macro).
  - dfp_resp=1 exactly once, 5 cycles after accept.
- Ready drop mid-burst: deassert bmem_ready during beat 2 → all 4 beats still emitted back-to-back.
- Read: dfp_read=1, addr=0x1000 → one bmem_read pulse with bmem_addr=0x1000. Then rvalid pattern 1,1,0,0,0,1,1 → busy falls the cycle after the 4th beat; dfp_resp never asserted.
- Simultaneous dfp_read and dfp_write in IDLE → write burst issued, no bmem_read.
- rst asserted after beat 1 of a write → next cycle bmem_write=0, state IDLE, no dfp_resp. A new write then completes normally.
